// File: rtl/lifo_rev_pkg.sv
// -----------------------------------------------------------------------------
// lifo_rev_pkg
// Shared definitions for the LIFO stream reverser:
//   - default data width, LIFO depth and LIFO read latency
//   - controller state encoding (FILL / DRAIN)
//   - CNT_W(): width of a counter that must hold the values 0..n
// -----------------------------------------------------------------------------
package lifo_rev_pkg;

  localparam int DEF_W      = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Width needed to represent every value 0..n inclusive.
  function automatic int CNT_W(input int n);
    if (n < 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/lifo_stream_reverser_buf.sv
// -----------------------------------------------------------------------------
// rev_out_buf
// Small synchronous FIFO that holds popped LIFO words ({last, data}) until the
// downstream consumer takes them. Contents and pointers are plain registers, so
// the head entry stays stable while the consumer stalls.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   flush         drop all entries (synchronous)
//   wr_en/wr_data push one {last, data} entry (ignored when full)
//   rd_en         pop the head entry (ignored when empty)
//   rd_data       head entry
//   valid         buffer not empty
//   occ           number of stored entries
// -----------------------------------------------------------------------------
module rev_out_buf
  import lifo_rev_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int ENTRIES = DEF_RD_LAT + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [W:0]                 wr_data,
  input  logic                       rd_en,
  output logic [W:0]                 rd_data,
  output logic                       valid,
  output logic [CNT_W(ENTRIES)-1:0]  occ
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OW = CNT_W(ENTRIES);

  logic [W:0]    mem_q [ENTRIES];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [OW-1:0] occ_q;
  logic          do_wr_s;
  logic          do_rd_s;

  // Pointers wrap explicitly because ENTRIES need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(ENTRIES - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign do_wr_s = wr_en && (occ_q != OW'(ENTRIES));
  assign do_rd_s = rd_en && (occ_q != '0);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_rd_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      occ_q <= occ_q + OW'(do_wr_s) - OW'(do_rd_s);
    end
  end

  // Storage array; cleared on reset so out_last never shows stale data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr_s && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign valid   = (occ_q != '0);
  assign occ     = occ_q;

endmodule

// File: rtl/lifo_stream_reverser.sv
// -----------------------------------------------------------------------------
// lifo_stream_reverser
// Master side of a LIFO: FILL pushes one upstream frame into the LIFO, DRAIN
// pops it back out so the frame leaves in reverse order.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last      upstream valid/ready stream
//   out_valid/out_ready/out_data/out_last  downstream reversed stream
//   lifo_wn/lifo_rn/lifo_datain            push/pop strobes and push data
//   lifo_dataout/lifo_full/lifo_empty      LIFO pop data (RD_LAT after rn), flags
//   err_split   1-cycle pulse: frame longer than DEPTH was cut into two frames
//   err_under   1-cycle pulse: LIFO ran empty while words were still expected
// -----------------------------------------------------------------------------
module lifo_stream_reverser
  import lifo_rev_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         lifo_wn,
  output logic         lifo_rn,
  output logic [W-1:0] lifo_datain,
  input  logic [W-1:0] lifo_dataout,
  input  logic         lifo_full,
  input  logic         lifo_empty,
  output logic         err_split,
  output logic         err_under
);

  localparam int CW = CNT_W(DEPTH);
  localparam int BD = RD_LAT + 1;     // output buffer entries
  localparam int OW = CNT_W(BD);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW:0]   BD_C    = (OW + 1)'(BD);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d, rem_q, rem_d, cnt_inc_s;
  logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [OW-1:0]       inflight_q, inflight_d;
  logic                err_split_q, err_split_d, err_under_q, err_under_d;
  logic                accept_s, pop_s, want_issue_s, issue_s, under_s;
  logic                capture_s, frame_done_s;
  logic [OW:0]         credit_s;
  logic [W:0]          buf_rd_s;
  logic                buf_vld_s;
  logic [OW-1:0]       buf_occ_s;

  assign in_ready  = !reset && (state_q == ST_FILL) && !lifo_full && (cnt_q < DEPTH_C);
  assign accept_s  = in_valid && in_ready;
  assign cnt_inc_s = cnt_q + CW'(1);

  assign pop_s        = buf_vld_s && out_ready;
  assign frame_done_s = pop_s && buf_rd_s[W];

  // Words in flight plus buffered words, less the one leaving this cycle, must
  // stay below the buffer size; counting the same-cycle pop keeps full rate.
  assign credit_s     = {1'b0, inflight_q} + {1'b0, buf_occ_s} - {{OW{1'b0}}, pop_s};
  assign want_issue_s = !reset && (state_q == ST_DRAIN) && (rem_q != '0) && (credit_s < BD_C);
  assign issue_s      = want_issue_s && !lifo_empty;
  assign under_s      = want_issue_s && lifo_empty;
  assign capture_s    = pipe_vld_q[RD_LAT-1];

  assign lifo_wn     = accept_s;
  assign lifo_rn     = issue_s;
  assign lifo_datain = in_data;

  // Next-state logic: FSM, counters, read-latency tag pipe and credit count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    err_split_d = 1'b0;
    err_under_d = 1'b0;
    pipe_vld_d  = pipe_vld_q;
    pipe_last_d = pipe_last_q;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
    pipe_vld_d[0]  = issue_s;
    pipe_last_d[0] = (rem_q == CW'(1));
    inflight_d     = inflight_q + OW'(issue_s) - OW'(capture_s);

    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          cnt_d = cnt_inc_s;
          if (in_last || (cnt_inc_s == DEPTH_C)) begin
            state_d     = ST_DRAIN;
            rem_d       = cnt_inc_s;
            err_split_d = !in_last;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DRAIN: begin
        if (under_s) begin
          state_d     = ST_FILL;
          cnt_d       = '0;
          rem_d       = '0;
          err_under_d = 1'b1;
          pipe_vld_d  = '0;
          inflight_d  = '0;
        end else if (frame_done_s) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end else if (issue_s) begin
          rem_d = rem_q - CW'(1);
        end else begin
          rem_d = rem_q;
        end
      end
      default: begin
        state_d = ST_FILL;
        cnt_d   = '0;
        rem_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      rem_q       <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      inflight_q  <= '0;
      err_split_q <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      inflight_q  <= inflight_d;
      err_split_q <= err_split_d;
      err_under_q <= err_under_d;
    end
  end

  rev_out_buf #(
    .W       (W),
    .ENTRIES (BD)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .flush   (under_s),
    .wr_en   (capture_s),
    .wr_data ({pipe_last_q[RD_LAT-1], lifo_dataout}),
    .rd_en   (pop_s),
    .rd_data (buf_rd_s),
    .valid   (buf_vld_s),
    .occ     (buf_occ_s)
  );

  assign out_valid = buf_vld_s;
  assign out_data  = buf_rd_s[W-1:0];
  assign out_last  = buf_vld_s && buf_rd_s[W];
  assign err_split = err_split_q;
  assign err_under = err_under_q;

endmodule

// File: tb/tb_lifo_stream_reverser.sv
// -----------------------------------------------------------------------------
// tb_lifo_stream_reverser
// Directed bench: the reverser paired with a behavioural LIFO (RD_LAT=2).
// -----------------------------------------------------------------------------
module tb_lifo_stream_reverser;

  localparam int W      = 8;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         lifo_wn, lifo_rn;
  logic [W-1:0] lifo_datain, lifo_dataout;
  logic         lifo_full, lifo_empty;
  logic         err_split, err_under;
  logic         force_empty = 1'b0;

  always #5 clock = ~clock;

  lifo_stream_reverser #(.W(W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .lifo_wn(lifo_wn), .lifo_rn(lifo_rn), .lifo_datain(lifo_datain),
    .lifo_dataout(lifo_dataout), .lifo_full(lifo_full), .lifo_empty(lifo_empty),
    .err_split(err_split), .err_under(err_under)
  );

  // Behavioural LIFO: pop data registered twice -> valid RD_LAT=2 after rn.
  logic [W-1:0] stk [DEPTH];
  int           sp;
  logic [W-1:0] rd_s1, rd_s2;

  always @(posedge clock) begin
    if (reset) begin
      sp    <= 0;
      rd_s1 <= '0;
      rd_s2 <= '0;
    end else begin
      if (lifo_wn && sp < DEPTH) begin
        stk[sp] <= lifo_datain;
        sp      <= sp + 1;
      end else if (lifo_rn && sp > 0) begin
        rd_s1 <= stk[sp-1];
        sp    <= sp - 1;
      end
      rd_s2 <= rd_s1;
    end
  end

  assign lifo_full    = (sp == DEPTH);
  assign lifo_empty   = (sp == 0) || force_empty;
  assign lifo_dataout = rd_s2;

  // Output monitor: records accepted beats, error pulses, stall and strobe violations.
  logic [W-1:0] got_d [$];
  logic         got_l [$];
  int           split_seen = 0, under_seen = 0, stall_bad = 0, both_bad = 0;
  logic         stalled = 1'b0;
  logic [W:0]   held = '0;

  always @(negedge clock) begin
    if (lifo_wn && lifo_rn) both_bad <= both_bad + 1;
    if (reset) begin
      stalled <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      if (err_split) split_seen <= split_seen + 1;
      if (err_under) under_seen <= under_seen + 1;
      if (stalled && !(out_valid && {out_last, out_data} == held)) stall_bad <= stall_bad + 1;
      stalled <= out_valid && !out_ready;
      held    <= {out_last, out_data};
    end
  end

  int           vectors = 0, miscompares = 0;
  logic [W-1:0] frm [$];
  logic [W-1:0] exp_d [$];
  logic         exp_l [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame();
    int n;
    for (int i = 0; i < frm.size(); i++) begin
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = (i == frm.size() - 1);
      n = 0;
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) chk("push_ready_timeout", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int toggle);
    int cyc;
    cyc = 0;
    while (got_d.size() < target && cyc < 300) begin
      out_ready = (toggle == 0) ? 1'b1 : ((cyc % 3) == 0);
      tick();
      cyc++;
    end
    chk("beat_count", 32'(got_d.size()), 32'(target));
  endtask

  task automatic cmp_frame(input string tag, input int base);
    for (int i = 0; i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got_d[base+i]), 32'(exp_d[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_l[base+i]), 32'(exp_l[i]));
    end
  endtask

  int base, snap;

  initial begin
    // Reset state.
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_wn", 32'(lifo_wn), 32'd0);
    chk("rst_rn", 32'(lifo_rn), 32'd0);
    chk("rst_err", 32'({err_split, err_under}), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: seven-beat frame, consumer always ready, latency RD_LAT+1.
    out_ready = 1'b1;
    base = got_d.size();
    frm = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};
    push_frame();
    chk("t1_first_rn", 32'(lifo_rn), 32'd1);
    chk("t1_in_ready_drain", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid_on_time", 32'(out_valid), 32'd1);
    chk("t1_first_data", 32'(out_data), 32'd15);
    wait_beats(base + 7, 0);
    exp_d = '{8'd15, 8'd65, 8'd70, 8'd40, 8'd200, 8'd150, 8'd100};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmp_frame("t1", base);
    tick();
    chk("t1_lifo_empty", 32'(lifo_empty), 32'd1);
    chk("t1_back_to_fill", 32'(in_ready), 32'd1);

    // 2: same frame, consumer ready pattern 1,0,0,...
    base = got_d.size();
    push_frame();
    wait_beats(base + 7, 1);
    out_ready = 1'b0;
    repeat (5) tick();
    chk("t2_no_dup", 32'(got_d.size()), 32'(base + 7));
    cmp_frame("t2", base);

    // 3: one-beat frame, then a following frame.
    out_ready = 1'b1;
    base = got_d.size();
    frm = '{8'd42};
    push_frame();
    wait_beats(base + 1, 0);
    exp_d = '{8'd42};
    exp_l = '{1'b1};
    cmp_frame("t3a", base);
    chk("t3_fill", 32'(in_ready), 32'd1);
    base = got_d.size();
    frm = '{8'd11, 8'd12};
    push_frame();
    wait_beats(base + 2, 0);
    exp_d = '{8'd12, 8'd11};
    exp_l = '{1'b0, 1'b1};
    cmp_frame("t3b", base);

    // 4: ten-beat frame splits at DEPTH.
    base = got_d.size();
    snap = split_seen;
    frm.delete();
    for (int i = 1; i <= 10; i++) frm.push_back(8'(i));
    push_frame();
    wait_beats(base + 10, 0);
    exp_d = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd10, 8'd9};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cmp_frame("t4", base);
    chk("t4_split_pulses", 32'(split_seen - snap), 32'd1);

    // 5: reset after three outputs of a five-beat frame.
    base = got_d.size();
    frm = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    push_frame();
    wait_beats(base + 3, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    exp_d = '{8'd5, 8'd4, 8'd3};
    exp_l = '{1'b0, 1'b0, 1'b0};
    cmp_frame("t5a", base);
    base = got_d.size();
    frm = '{8'd5, 8'd6};
    push_frame();
    wait_beats(base + 2, 0);
    exp_d = '{8'd6, 8'd5};
    exp_l = '{1'b0, 1'b1};
    cmp_frame("t5b", base);

    // 6: LIFO reports empty on the first issue of a three-word frame.
    out_ready = 1'b0;
    snap = under_seen;
    frm = '{8'd7, 8'd8, 8'd9};
    push_frame();
    force_empty = 1'b1;
    #1;
    chk("t6_no_rn", 32'(lifo_rn), 32'd0);
    tick();
    chk("t6_err_under", 32'(err_under), 32'd1);
    chk("t6_fill", 32'(in_ready), 32'd1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    force_empty = 1'b0;
    tick();
    chk("t6_err_under_pulse", 32'(err_under), 32'd0);
    chk("t6_under_pulses", 32'(under_seen - snap), 32'd1);
    chk("t6_rn_idle", 32'(lifo_rn), 32'd0);

    chk("stall_stable", 32'(stall_bad), 32'd0);
    chk("wn_rn_exclusive", 32'(both_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
